// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, FSM states,
// ALU function codes and datapath select encodings.
package cpu_pkg;

    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_AND    = 6'd2;
    localparam logic [5:0] OP_OR     = 6'd3;
    localparam logic [5:0] OP_COM    = 6'd4;
    localparam logic [5:0] OP_ADDI   = 6'd5;
    localparam logic [5:0] OP_SUBI   = 6'd6;
    localparam logic [5:0] OP_ANDI   = 6'd7;
    localparam logic [5:0] OP_ORI    = 6'd8;
    localparam logic [5:0] OP_LDI    = 6'd9;
    localparam logic [5:0] OP_LUI    = 6'd10;
    localparam logic [5:0] OP_LW     = 6'd11;
    localparam logic [5:0] OP_SW     = 6'd12;
    localparam logic [5:0] OP_LWI    = 6'd13;
    localparam logic [5:0] OP_SWI    = 6'd14;
    localparam logic [5:0] OP_BNZ    = 6'd15;
    localparam logic [5:0] OP_BPL    = 6'd16;
    localparam logic [5:0] OP_JMP    = 6'd17;
    localparam logic [5:0] OP_JR     = 6'd18;
    localparam logic [5:0] OP_JAL    = 6'd19;
    localparam logic [5:0] OP_FPADD  = 6'd20;
    localparam logic [5:0] OP_FPMULT = 6'd21;
    localparam logic [5:0] OP_MAX    = 6'd21;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_FP_WAIT = 3'd5,
        S_WB      = 3'd6,
        S_TRAP    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_COM   = 4'd4,
        ALU_PASSA = 4'd5,
        ALU_PASSB = 4'd6,
        ALU_LUI   = 4'd7
    } alu_op_t;

    localparam logic [1:0] PC_SEL_INC = 2'd0;
    localparam logic [1:0] PC_SEL_IMM = 2'd1;
    localparam logic [1:0] PC_SEL_RZ  = 2'd2;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC  = 2'd2;
    localparam logic [1:0] WB_SEL_FP  = 2'd3;

    typedef struct packed {
        alu_op_t op;
        logic    imm;
    } alu_ctl_t;

    // Operations without an ALU role fall back to a plain ADD of registers.
    function automatic alu_ctl_t alu_ctrl(input logic [5:0] op);
        alu_ctl_t ctl;
        ctl.op  = ALU_ADD;
        ctl.imm = 1'b0;
        case (op)
            OP_ADD:        ctl.op = ALU_ADD;
            OP_SUB:        ctl.op = ALU_SUB;
            OP_AND:        ctl.op = ALU_AND;
            OP_OR:         ctl.op = ALU_OR;
            OP_COM:        ctl.op = ALU_COM;
            OP_ADDI:       begin ctl.op = ALU_ADD;   ctl.imm = 1'b1; end
            OP_SUBI:       begin ctl.op = ALU_SUB;   ctl.imm = 1'b1; end
            OP_ANDI:       begin ctl.op = ALU_AND;   ctl.imm = 1'b1; end
            OP_ORI:        begin ctl.op = ALU_OR;    ctl.imm = 1'b1; end
            OP_LDI:        begin ctl.op = ALU_PASSB; ctl.imm = 1'b1; end
            OP_LUI:        begin ctl.op = ALU_LUI;   ctl.imm = 1'b1; end
            OP_LW, OP_SW:  ctl.op = ALU_PASSA;
            OP_LWI, OP_SWI: begin ctl.op = ALU_PASSB; ctl.imm = 1'b1; end
            default:       ctl.op = ALU_ADD;
        endcase
        return ctl;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LWI);
    endfunction

endpackage

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/FP-wait/write-back
// with a sticky trap state, an FP timeout counter and a retired-instruction counter.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int FP_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero_flag,
    input  logic             neg_flag,
    input  logic             mem_ready,
    input  logic             fp_done,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_sel,
    output logic             addr_sel,
    output logic             mem_re,
    output logic             mem_we,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             fp_start,
    output logic             fp_op,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    localparam int FPC_W = (FP_TIMEOUT > 2) ? $clog2(FP_TIMEOUT) : 1;
    localparam logic [FPC_W-1:0] FP_LAST = FPC_W'(FP_TIMEOUT - 1);

    state_t            state_r;
    state_t            state_s;
    logic [5:0]        op_r;
    logic [FPC_W-1:0]  fp_cnt_r;
    logic [CNT_W-1:0]  retired_r;
    logic              retire_s;
    alu_ctl_t          alu_ctl_s;

    assign retired = retired_r;

    // State register, latched opcode, FP timeout counter and retired counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            op_r      <= 6'd0;
            fp_cnt_r  <= '0;
            retired_r <= '0;
        end else begin
            state_r <= state_s;
            if (state_r == S_DECODE) begin
                op_r <= opcode;
            end
            if (state_r == S_EXEC) begin
                fp_cnt_r <= '0;
            end else if (state_r == S_FP_WAIT) begin
                fp_cnt_r <= fp_cnt_r + FPC_W'(1);
            end
            if (retire_s) begin
                retired_r <= retired_r + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode from the current state and latched opcode.
    always_comb begin
        state_s     = state_r;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        pc_sel      = PC_SEL_INC;
        addr_sel    = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_SEL_ALU;
        fp_start    = 1'b0;
        fp_op       = 1'b0;
        trap        = 1'b0;
        alu_ctl_s   = alu_ctrl(op_r);

        case (state_r)
            S_IDLE: begin
                state_s = S_FETCH;
            end
            S_FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                    state_s = S_DECODE;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Decide on the live opcode; op_r only holds it from EXEC onward.
                if (opcode > OP_MAX) begin
                    state_s = S_TRAP;
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op      = alu_ctl_s.op;
                alu_src_imm = alu_ctl_s.imm;
                case (op_r)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_COM,
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LDI, OP_LUI: begin
                        state_s = S_WB;
                    end
                    OP_LW, OP_SW, OP_LWI, OP_SWI: begin
                        state_s = S_MEM;
                    end
                    OP_BNZ, OP_BPL: begin
                        if (((op_r == OP_BNZ) && !zero_flag) || ((op_r == OP_BPL) && !neg_flag)) begin
                            pc_load = 1'b1;
                            pc_sel  = PC_SEL_IMM;
                        end else begin
                            pc_load = 1'b0;
                        end
                        state_s = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                        pc_sel  = PC_SEL_IMM;
                        state_s = S_FETCH;
                    end
                    OP_JR: begin
                        pc_load = 1'b1;
                        pc_sel  = PC_SEL_RZ;
                        state_s = S_FETCH;
                    end
                    OP_JAL: begin
                        state_s = S_WB;
                    end
                    OP_FPADD, OP_FPMULT: begin
                        fp_start = 1'b1;
                        fp_op    = (op_r == OP_FPMULT);
                        state_s  = S_FP_WAIT;
                    end
                    default: begin
                        state_s = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                addr_sel    = 1'b1;
                alu_op      = alu_ctl_s.op;
                alu_src_imm = alu_ctl_s.imm;
                if (is_load(op_r)) begin
                    mem_re = 1'b1;
                end else begin
                    mem_we = 1'b1;
                end
                if (!mem_ready) begin
                    state_s = S_MEM;
                end else if (is_load(op_r)) begin
                    state_s = S_WB;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_FP_WAIT: begin
                fp_op = (op_r == OP_FPMULT);
                // A result arriving on the final count still completes normally.
                if (fp_done) begin
                    state_s = S_WB;
                end else if (fp_cnt_r == FP_LAST) begin
                    state_s = S_TRAP;
                end else begin
                    state_s = S_FP_WAIT;
                end
            end
            S_WB: begin
                reg_we      = 1'b1;
                alu_op      = alu_ctl_s.op;
                alu_src_imm = alu_ctl_s.imm;
                case (op_r)
                    OP_LW, OP_LWI:       wb_sel = WB_SEL_MEM;
                    OP_JAL: begin
                        wb_sel  = WB_SEL_PC;
                        pc_load = 1'b1;
                        pc_sel  = PC_SEL_IMM;
                    end
                    OP_FPADD, OP_FPMULT: wb_sel = WB_SEL_FP;
                    default:             wb_sel = WB_SEL_ALU;
                endcase
                state_s = S_FETCH;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_s = S_TRAP;
            end
            default: begin
                state_s = S_TRAP;
            end
        endcase

        retire_s = (state_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_IDLE);
    end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle control sequencer for the 32-bit, 22-opcode core. It drives instruction fetch, instruction-register load, PC update, ALU/immediate selection, memory strobes, register write-back and the start/done handshake of the multi-cycle FP unit (FPADD/FPMULT). It consumes the decoded `opcode` and the datapath flags, and sits between the instruction register, register file, ALU, FP unit and the unified memory port.

## Interface
- `FP_TIMEOUT`, 64: maximum number of cycles spent in FP_WAIT before trapping (≥2).
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `opcode`  in  6  opcode from the instruction register; valid from DECODE onward.
- `zero_flag`  in  1  Rz==0 from the datapath; sampled in EXEC.
- `neg_flag`  in  1  Rz<0 (bit 31); sampled in EXEC.
- `mem_ready`  in  1  memory port completes the current read or write this cycle.
- `fp_done`  in  1  FP unit result valid; one-cycle pulse.
- `ir_load`  out  1  load the instruction register from memory data.
- `pc_load`  out  1  update the PC.
- `pc_sel`  out  2  0 = PC+1, 1 = Imm, 2 = Rz (JR).
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `mem_re`, `mem_we`  out  1  memory read / write strobes.
- `alu_op`  out  4  ALU function code (package enum).
- `alu_src_imm`  out  1  ALU B operand: 1 = Imm, 0 = Rx.
- `reg_we`  out  1  register-file write enable.
- `wb_sel`  out  2  0 = ALU, 1 = memory, 2 = PC (link), 3 = FP.
- `fp_start`  out  1  one-cycle start pulse to the FP unit.
- `fp_op`  out  1  0 = FPADD, 1 = FPMULT.
- `trap`  out  1  sticky: illegal opcode or FP timeout.
- `retired`  out  CNT_W  count of completed instructions; wraps.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, FP_WAIT, WB, TRAP. Outputs are Moore-decoded from the state and `op_q`.
- IDLE: all outputs 0. Go to FETCH.
- FETCH: `addr_sel`=0 and `mem_re`=1 are held until `mem_ready`. In the `mem_ready` cycle, assert `ir_load`=1 and `pc_load`=1 with `pc_sel`=0, then go to DECODE.
- DECODE: latch `opcode` into `op_q`. Opcode >21 → TRAP. Otherwise go to EXEC.
- EXEC, by opcode:
  - ADD/SUB/AND/OR/COM, and their I-forms with `alu_src_imm`=1: ALU op → WB.
  - LDI: PASSB with imm → WB.
  - LUI: LUI op with imm → WB.
  - LW/SW: PASSA (address = Ry) → MEM.
  - LWI/SWI: PASSB with imm → MEM.
  - BNZ: taken if `zero_flag`==0. BPL: taken if `neg_flag`==0. Taken → `pc_load`=1, `pc_sel`=1. Either way → FETCH.
  - JMP: `pc_load`, `pc_sel`=1 → FETCH.
  - JR: `pc_load`, `pc_sel`=2 → FETCH.
  - JAL: → WB with `wb_sel`=2 (link = already-incremented PC); the PC update to Imm happens in WB.
  - FPADD/FPMULT: `fp_start`=1, `fp_op` set, clear the timeout counter → FP_WAIT.
- MEM: `addr_sel`=1, with `mem_re` (loads) or `mem_we` (stores) held until `mem_ready`. Then loads → WB with `wb_sel`=1; stores → FETCH.
- FP_WAIT: `fp_op` is held. `fp_done` → WB with `wb_sel`=3. If the counter reaches FP_TIMEOUT−1 without `fp_done` → TRAP. If `fp_done` and the timeout occur in the same cycle, `fp_done` wins.
- WB: `reg_we`=1 for one cycle; JAL also asserts `pc_load`, `pc_sel`=1. Then → FETCH.
- TRAP: all strobes 0 and `trap`=1. Leaves TRAP only on reset.
- `retired` increments on every transition into FETCH except from IDLE.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, `op_q`=0, counters 0, `trap`=0, every output 0. Reset mid-instruction aborts immediately; no pending strobe survives.
- First FETCH strobe appears 1 cycle after `rst_n` rises (IDLE occupies one cycle).
- Latency with zero-wait memory:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch/jump: 3 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - FP: 4 cycles plus the FP_WAIT cycles.
- Each `mem_ready` wait cycle adds exactly one cycle. `mem_ready` outside FETCH/MEM is ignored. A `mem_ready` that is already high on entry completes in the entry cycle.
- `fp_start` is exactly one cycle per FP instruction. `fp_done` outside FP_WAIT is ignored.
- `retired` wraps from 2^CNT_W−1 to 0.

## Structure
- Package `cpu_pkg` holds:
  - the opcode constants (ADD=0 … FPMULT=21);
  - the state enum;
  - the `alu_op` enum: ADD, SUB, AND, OR, COM, PASSA, PASSB, LUI;
  - the `pc_sel` and `wb_sel` encodings.
- Single module; no sub-module. The FP timeout counter and the retired counter are inline.

## Test plan
- Reset, then ADDI with zero-wait memory → `ir_load` at cycle 1, `reg_we`=1 with `wb_sel`=0 and `alu_src_imm`=1 at cycle 4, `retired`=1.
- LW with `mem_ready` delayed 3 cycles in MEM → `mem_re`/`addr_sel`=1 held 4 cycles, then `reg_we` with `wb_sel`=1; total 8 cycles.
- BNZ with `zero_flag`=0 → `pc_load`, `pc_sel`=1 in EXEC. BNZ with `zero_flag`=1 → no `pc_load` in EXEC. JAL → `reg_we`, `wb_sel`=2, `pc_sel`=1 in WB.
- FPMULT with `fp_done` after 5 cycles → a single `fp_start`, `fp_op`=1, then WB with `wb_sel`=3. With FP_TIMEOUT=8 and no `fp_done` → `trap`=1 after 8 FP_WAIT cycles; `fp_done` coinciding with the last count → WB, no trap.
- Opcode 40 → TRAP after DECODE, strobes stay 0. Asserting `rst_n`=0 in the middle of a MEM wait → all outputs 0 immediately and restart from IDLE.
